mac_dot_ctrl: RTL and testbench

MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

---
 rtl/mac_ctrl_pkg.sv | 20 ++
 rtl/mac_dot_ctrl_if.sv | 40 ++++
 rtl/mac_acc.sv | 72 +++++++
 rtl/mac_dot_ctrl.sv | 103 ++++++++++
 tb/tb_mac_dot_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mac_ctrl_pkg
// Shared definitions for the dot-product MAC controller slice.
//   state_t        : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_N      : default operand width
//   DEFAULT_LEN_W  : default width of the element-count field
// Optional build macro used elsewhere in this slice: MAC_CTRL_SAT_EN.
// ---------------------------------------------------------------------------
package mac_ctrl_pkg;

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_dot_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl_if
// Job, operand-stream and result signals of the dot-product controller.
//   start/len          : job request and element count
//   in_valid/in_ready  : operand handshake carrying in_a/in_b
//   out_valid/out_ready: result handshake carrying out_mac/ovf
//   busy               : controller is not idle
// Modports: master = job/operand producer and result consumer,
//           slave  = the controller itself.
// ---------------------------------------------------------------------------
interface mac_dot_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int LEN_W = DEFAULT_LEN_W
);

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_mac;
    logic             busy;
    logic             ovf;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_mac, busy, ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_mac, busy, ovf
    );

endinterface

// File: rtl/mac_acc.sv
// ---------------------------------------------------------------------------
// mac_acc
// Accumulator register of the dot-product controller: on each enabled cycle
// adds the full 2N-bit product a*b to the running sum.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of sum and overflow flag (wins over en)
//   en       : add a*b this cycle
//   a, b     : unsigned N-bit operands
//   acc      : running 2N-bit sum
//   ovf      : sticky overflow flag
// Build macro MAC_CTRL_SAT_EN: when defined the sum clamps at all-ones and
// ovf is set; otherwise the sum wraps modulo 2^(2N) and ovf is tied low.
// ---------------------------------------------------------------------------
module mac_acc
    import mac_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] acc,
    output logic           ovf
);

    logic [2*N-1:0] prod;

    // Operands are widened first so the multiply is carried out at 2N bits.
    assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

`ifdef MAC_CTRL_SAT_EN
    logic [2*N:0] sum;

    // One extra bit catches the carry out of the 2N-bit sum.
    assign sum = {1'b0, acc} + {1'b0, prod};

    // Once clamped, any further non-zero product carries out again, so the
    // register stays at all-ones without extra state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (sum[2*N]) begin
                acc <= '1;
                ovf <= 1'b1;
            end else begin
                acc <= sum[2*N-1:0];
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl
// Dot-product controller: accepts a job (start + len), consumes len operand
// pairs over a valid/ready stream, accumulates sum(a*b) and presents the
// result until the consumer takes it.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mac_dot_ctrl_if slave modport (start, len, in_valid/in_ready,
//              in_a, in_b, out_valid/out_ready, out_mac, busy, ovf)
// out_mac always reflects the live accumulator, so it is zero in reset and
// after a job is started, and holds the final sum while in DONE.
// Build macro MAC_CTRL_SAT_EN selects saturating accumulation (see mac_acc).
// ---------------------------------------------------------------------------
module mac_dot_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic           clk,
    input  logic           rst,
    mac_dot_ctrl_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic             beat;
    logic             last_beat;
    logic             acc_clr;
    logic [2*N-1:0]   acc;
    logic             acc_ovf;

    assign beat      = (state == RUN) && bus.in_valid;
    assign last_beat = beat && (cnt == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-length job skips RUN; the accumulator is still cleared so the
    // reported result is zero. In DONE, start is deliberately not looked at,
    // so a start coinciding with the result handshake is dropped.
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_clr   = 1'b1;
                    state_nxt = (bus.len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Remaining-beat counter: loaded on an accepted start, decremented per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cnt <= bus.len;
        end else if (beat) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    mac_acc #(
        .N (N)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (beat),
        .a   (bus.in_a),
        .b   (bus.in_b),
        .acc (acc),
        .ovf (acc_ovf)
    );

    assign bus.in_ready  = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_mac   = acc;
    assign bus.ovf       = acc_ovf;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_ctrl
// Directed and randomized bench for mac_dot_ctrl with N=8, LEN_W=8.
// Expected results come from a sum-of-products reference computed with plain
// integer arithmetic (wrapping, or clamping when MAC_CTRL_SAT_EN is defined).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mac_dot_ctrl;

    localparam int N  = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int unsigned mdl_acc;
    int unsigned mdl_ovf;

    mac_dot_ctrl_if #(.N(N), .LEN_W(LW)) bus ();

    mac_dot_ctrl #(
        .N     (N),
        .LEN_W (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; returns at the next falling edge.
    task automatic applyStimulus(input int st, input int ln, input int iv,
                                 input int a, input int b, input int ordy);
        bus.start     = 1'(st);
        bus.len       = 8'(ln);
        bus.in_valid  = 1'(iv);
        bus.in_a      = 8'(a);
        bus.in_b      = 8'(b);
        bus.out_ready = 1'(ordy);
        @(negedge clk);
    endtask

    function automatic void modelClear();
        mdl_acc = 0;
        mdl_ovf = 0;
    endfunction

    function automatic void modelAdd(input int unsigned a, input int unsigned b);
        int unsigned s;
        s = mdl_acc + a * b;
`ifdef MAC_CTRL_SAT_EN
        if (s > 65535) begin
            mdl_acc = 65535;
            mdl_ovf = 1;
        end else begin
            mdl_acc = s;
        end
`else
        mdl_acc = s % 65536;
`endif
    endfunction

    // Check a presented result against the model, then take it.
    task automatic finishJob(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 1);
        checkOutput({tag, "_mac"}, 32'(bus.out_mac), mdl_acc);
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), mdl_ovf);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput({tag, "_idle"}, 32'(bus.busy), 0);
        checkOutput({tag, "_novalid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int unsigned len;
        int unsigned a;
        int unsigned b;
        int unsigned waits;
        int unsigned stalls;

        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_out_mac", 32'(bus.out_mac), 0);
        checkOutput("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        // Three back-to-back beats: 2*3 + 4*5 + 6*7 = 68
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("basic_busy", 32'(bus.busy), 1);
        checkOutput("basic_in_ready", 32'(bus.in_ready), 1);
        applyStimulus(0, 0, 1, 2, 3, 0);
        applyStimulus(0, 0, 1, 4, 5, 0);
        checkOutput("basic_early_valid", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 1, 6, 7, 0);
        checkOutput("basic_in_ready_done", 32'(bus.in_ready), 0);
        checkOutput("basic_mac68", 32'(bus.out_mac), 68);
        modelClear();
        modelAdd(2, 3);
        modelAdd(4, 5);
        modelAdd(6, 7);
        finishJob("basic");

        // Four (1,1) beats with two stall cycles between them
        applyStimulus(1, 4, 0, 0, 0, 0);
        modelClear();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, 1, 0);
            modelAdd(1, 1);
            if (i < 3) begin
                for (int s = 0; s < 2; s++) begin
                    applyStimulus(0, 0, 0, 1, 1, 0);
                    checkOutput("stall_mac", 32'(bus.out_mac), i + 1);
                    checkOutput("stall_in_ready", 32'(bus.in_ready), 1);
                end
            end
        end
        checkOutput("stall_mac4", 32'(bus.out_mac), 4);
        finishJob("stall");

        // Zero-length job goes straight to DONE and holds while out_ready=0
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("len0_valid", 32'(bus.out_valid), 1);
        checkOutput("len0_mac", 32'(bus.out_mac), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("len0_hold_valid", 32'(bus.out_valid), 1);
            checkOutput("len0_hold_mac", 32'(bus.out_mac), 0);
        end
        modelClear();
        finishJob("len0");

        // (255,255) twice: 0x1FC02 wraps to 0xFC02, or clamps to 0xFFFF
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 255, 255, 0);
        applyStimulus(0, 0, 1, 255, 255, 0);
`ifdef MAC_CTRL_SAT_EN
        checkOutput("big_mac", 32'(bus.out_mac), 32'h0000_FFFF);
        checkOutput("big_ovf", 32'(bus.ovf), 1);
`else
        checkOutput("big_mac", 32'(bus.out_mac), 32'h0000_FC02);
        checkOutput("big_ovf", 32'(bus.ovf), 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("big_idle", 32'(bus.busy), 0);

        // Reset in the middle of a job, then a fresh one-beat job
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 5, 6, 0);
        applyStimulus(0, 0, 1, 7, 8, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy), 0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 0);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("midrst_mac", 32'(bus.out_mac), 0);
        checkOutput("midrst_ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_after_busy", 32'(bus.busy), 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 3, 0);
        checkOutput("midrst_mac9", 32'(bus.out_mac), 9);
        modelClear();
        modelAdd(3, 3);
        finishJob("midrst");

        // start pulses while in RUN and DONE are ignored
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("ign_run_in_ready", 32'(bus.in_ready), 1);
        applyStimulus(0, 0, 1, 10, 20, 0);
        applyStimulus(0, 0, 1, 3, 4, 0);
        checkOutput("ign_valid", 32'(bus.out_valid), 1);
        applyStimulus(1, 7, 0, 0, 0, 0);
        checkOutput("ign_done_valid", 32'(bus.out_valid), 1);
        checkOutput("ign_done_mac", 32'(bus.out_mac), 212);
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkOutput("ign_hs_busy", 32'(bus.busy), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ign_hs_still_idle", 32'(bus.busy), 0);

        // Randomized jobs with random stalls and result back-pressure
        for (int j = 0; j < 25; j++) begin
            len = $urandom_range(1, 6);
            modelClear();
            applyStimulus(1, int'(len), 0, 0, 0, 0);
            for (int k = 0; k < int'(len); k++) begin
                stalls = $urandom_range(0, 2);
                for (int s = 0; s < int'(stalls); s++) begin
                    applyStimulus(0, 0, 0, 0, 0, 0);
                end
                a = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
                b = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
                checkOutput("rnd_in_ready", 32'(bus.in_ready), 1);
                applyStimulus(0, 0, 1, int'(a), int'(b), 0);
                modelAdd(a, b);
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < int'(waits); w++) begin
                checkOutput("rnd_hold_mac", 32'(bus.out_mac), mdl_acc);
                applyStimulus(0, 0, 0, 0, 0, 0);
            end
            finishJob("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
